// File: rtl/pwm_music_pkg.sv
// Shared sizing helpers and note constants for the polyphonic PWM music block.
// Note constants are half-periods in clocks for a 10 MHz clock, octave 4.
package pwm_music_pkg;

  localparam int DEF_PERIOD_BITS = 16;
  localparam int DEF_VOL_BITS    = 4;

  function automatic int calc_ch_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // One extra bit per doubling of voices keeps the full-volume sum in range.
  function automatic int calc_mix_w(input int vol_bits, input int channels);
    return vol_bits + calc_ch_w(channels);
  endfunction

  localparam logic [15:0] NOTE_C4 = 16'd19111;
  localparam logic [15:0] NOTE_D4 = 16'd17026;
  localparam logic [15:0] NOTE_E4 = 16'd15169;
  localparam logic [15:0] NOTE_F4 = 16'd14317;
  localparam logic [15:0] NOTE_G4 = 16'd12755;
  localparam logic [15:0] NOTE_A4 = 16'd11364;
  localparam logic [15:0] NOTE_B4 = 16'd10124;
  localparam logic [15:0] NOTE_C5 = 16'd9556;

endpackage

// File: rtl/pwm_tone_voice.sv
// One square-wave voice: half-period counter, square bit, volume with
// optional linear decay. A write restarts the phase and overrides decay.
module pwm_tone_voice #(
  parameter int PERIOD_BITS = 16,
  parameter int VOL_BITS    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [PERIOD_BITS-1:0] wr_period,
  input  logic [VOL_BITS-1:0]    wr_vol,
  input  logic                   wr_decay,
  input  logic                   decay_tick,
  output logic                   sq,
  output logic [VOL_BITS-1:0]    vol
);

  logic [PERIOD_BITS-1:0] p_q, p_d;
  logic [PERIOD_BITS-1:0] c_q, c_d;
  logic [VOL_BITS-1:0]    v_q, v_d;
  logic                   d_q, d_d;
  logic                   s_q, s_d;

  always_comb begin
    p_d = p_q;
    v_d = v_q;
    d_d = d_q;
    c_d = c_q;
    s_d = s_q;
    if (wr) begin
      p_d = wr_period;
      v_d = wr_vol;
      d_d = wr_decay;
      c_d = '0;
      s_d = 1'b0;
    end else begin
      if (p_q == '0) begin
        c_d = '0;
        s_d = 1'b0;
      end else if (c_q == p_q - PERIOD_BITS'(1)) begin
        c_d = '0;
        s_d = ~s_q;
      end else begin
        c_d = c_q + PERIOD_BITS'(1);
      end
      if (decay_tick && d_q && (v_q != '0)) begin
        v_d = v_q - VOL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      v_q <= '0;
      d_q <= 1'b0;
      c_q <= '0;
      s_q <= 1'b0;
    end else begin
      p_q <= p_d;
      v_q <= v_d;
      d_q <= d_d;
      c_q <= c_d;
      s_q <= s_d;
    end
  end

  assign sq  = s_q;
  assign vol = v_q;

endmodule

// File: rtl/pwm_music_poly.sv
// Polyphonic PWM music generator: CHANNELS tone voices mixed into a
// frame-latched duty value driving a single-bit PWM DAC output.
module pwm_music_poly
  import pwm_music_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int PERIOD_BITS = DEF_PERIOD_BITS,
  parameter int VOL_BITS    = DEF_VOL_BITS,
  parameter int DECAY_DIV   = 65536,
  localparam int CH_W       = calc_ch_w(CHANNELS),
  localparam int MIX_W      = calc_mix_w(VOL_BITS, CHANNELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [CH_W-1:0]        wr_chan,
  input  logic [PERIOD_BITS-1:0] wr_period,
  input  logic [VOL_BITS-1:0]    wr_vol,
  input  logic                   wr_decay,
  output logic                   pwm,
  output logic                   frame,
  output logic [MIX_W-1:0]       level,
  output logic [CHANNELS-1:0]    sq
);

  localparam int PRESC_W = $clog2(DECAY_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DECAY_DIV - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [MIX_W-1:0]    cnt_q, cnt_d;
  logic [MIX_W-1:0]    level_q, level_d;
  logic                frame_q, frame_d;
  logic                pwm_q, pwm_d;
  logic                decay_tick;
  logic                wrap;
  logic [MIX_W-1:0]    mix;
  logic [CHANNELS-1:0] sq_w;
  logic [VOL_BITS-1:0] vol_w [CHANNELS];

  assign decay_tick = (presc_q == PRESC_LAST);

  // Write port: wr_en is a single-cycle strobe accepted unconditionally on the
  // edge it is seen; there is no ready, and out-of-range channels drop it.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
    pwm_tone_voice #(
      .PERIOD_BITS(PERIOD_BITS),
      .VOL_BITS   (VOL_BITS)
    ) u_voice (
      .clk       (clk),
      .rst       (rst),
      .wr        (wr_en && (wr_chan == CH_W'(i))),
      .wr_period (wr_period),
      .wr_vol    (wr_vol),
      .wr_decay  (wr_decay),
      .decay_tick(decay_tick),
      .sq        (sq_w[i]),
      .vol       (vol_w[i])
    );
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sq_w[i]) mix = mix + MIX_W'(vol_w[i]);
    end
  end

  // cnt_q is the frame position the registered outputs will show next cycle,
  // so cnt_q == 0 both latches the mix and raises frame in the same cycle.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    wrap    = (cnt_q == '0);
    cnt_d   = cnt_q + MIX_W'(1);
    frame_d = wrap;
    level_d = wrap ? mix : level_q;
    pwm_d   = (cnt_q < level_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      frame_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      frame_q <= frame_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm   = pwm_q;
  assign frame = frame_q;
  assign level = level_q;
  assign sq    = sq_w;

endmodule

// File: tb/tb_pwm_music_poly.sv
// Bench for pwm_music_poly: a 2-voice and a 3-voice instance checked every
// cycle against a time-based model, plus hand-computed pins.
module tb_pwm_music_poly;

  localparam int NI   = 2;
  localparam int MAXC = 4;
  localparam int DIV  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en_a = 1'b0;
  logic [0:0]  wr_chan_a = '0;
  logic        wr_en_b = 1'b0;
  logic [1:0]  wr_chan_b = '0;
  logic [15:0] wr_period = '0;
  logic [3:0]  wr_vol = '0;
  logic        wr_decay = 1'b0;

  logic       pwm_a, frame_a, pwm_b, frame_b;
  logic [4:0] level_a;
  logic [5:0] level_b;
  logic [1:0] sq_a;
  logic [2:0] sq_b;

  pwm_music_poly #(.CHANNELS(2), .PERIOD_BITS(16), .VOL_BITS(4), .DECAY_DIV(DIV)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_chan(wr_chan_a), .wr_period(wr_period),
    .wr_vol(wr_vol), .wr_decay(wr_decay), .pwm(pwm_a), .frame(frame_a), .level(level_a), .sq(sq_a)
  );

  pwm_music_poly #(.CHANNELS(3), .PERIOD_BITS(16), .VOL_BITS(4), .DECAY_DIV(DIV)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_chan(wr_chan_b), .wr_period(wr_period),
    .wr_vol(wr_vol), .wr_decay(wr_decay), .pwm(pwm_b), .frame(frame_b), .level(level_b), .sq(sq_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each voice is a write record (period, volume, decay, write edge);
  // square and volume at edge t are closed-form functions of t.
  int nch[NI]  = '{2, 3};
  int flen[NI] = '{32, 64};
  int unsigned r_p[NI][MAXC];
  int unsigned r_v[NI][MAXC];
  int unsigned r_d[NI][MAXC];
  int unsigned r_n[NI][MAXC];
  int unsigned m_e = 0;
  int x_level[NI] = '{0, 0};
  int x_pwm[NI]   = '{0, 0};
  int x_frame[NI] = '{0, 0};
  int x_sq[NI]    = '{0, 0};

  function automatic int s_at(input int i, input int c, input int unsigned t);
    if (r_p[i][c] == 0 || t < r_n[i][c]) return 0;
    return int'(((t - r_n[i][c]) / r_p[i][c]) % 2);
  endfunction

  function automatic int v_at(input int i, input int c, input int unsigned t);
    int unsigned ticks;
    if (r_d[i][c] == 0) return int'(r_v[i][c]);
    ticks = t / DIV - r_n[i][c] / DIV;
    return (r_v[i][c] > ticks) ? int'(r_v[i][c] - ticks) : 0;
  endfunction

  task automatic model_step();
    int mix, k, ch;
    bit en;
    if (rst) begin
      m_e = 0;
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < MAXC; c++) begin
          r_p[i][c] = 0; r_v[i][c] = 0; r_d[i][c] = 0; r_n[i][c] = 0;
        end
        x_level[i] = 0; x_pwm[i] = 0; x_frame[i] = 0; x_sq[i] = 0;
      end
      return;
    end
    m_e++;
    for (int i = 0; i < NI; i++) begin
      mix = 0;
      for (int c = 0; c < nch[i]; c++) mix += s_at(i, c, m_e - 1) * v_at(i, c, m_e - 1);
      en = (i == 0) ? wr_en_a : wr_en_b;
      ch = (i == 0) ? int'(wr_chan_a) : int'(wr_chan_b);
      if (en && ch < nch[i]) begin
        r_p[i][ch] = wr_period; r_v[i][ch] = wr_vol; r_d[i][ch] = wr_decay; r_n[i][ch] = m_e;
      end
      k = int'((m_e - 1) % flen[i]);
      x_frame[i] = (k == 0);
      if (k == 0) x_level[i] = mix;
      x_pwm[i] = (k < x_level[i]);
      x_sq[i] = 0;
      for (int c = 0; c < nch[i]; c++) if (s_at(i, c, m_e) != 0) x_sq[i] |= (1 << c);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // scoreboard compare, every cycle away from the active edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("pwm_a", pwm_a, x_pwm[0]);
      check("frame_a", frame_a, x_frame[0]);
      check("level_a", level_a, x_level[0]);
      check("sq_a", sq_a, x_sq[0]);
      check("pwm_b", pwm_b, x_pwm[1]);
      check("frame_b", frame_b, x_frame[1]);
      check("level_b", level_b, x_level[1]);
      check("sq_b", sq_b, x_sq[1]);
    end
  end

  // driver tasks (called at #1 after a rising edge)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_a(input int ch, input int p, input int v, input int d);
    wr_en_a = 1'b1; wr_chan_a = 1'(ch); wr_period = 16'(p); wr_vol = 4'(v); wr_decay = 1'(d);
    tick(1);
    wr_en_a = 1'b0;
  endtask

  task automatic write_b(input int ch, input int p, input int v, input int d);
    wr_en_b = 1'b1; wr_chan_b = 2'(ch); wr_period = 16'(p); wr_vol = 4'(v); wr_decay = 1'(d);
    tick(1);
    wr_en_b = 1'b0;
  endtask

  task automatic frame_high_count(input string name, input int target, input int max_cycles);
    bit ok;
    int cnt;
    ok = 1'b0;
    for (int j = 0; j < max_cycles; j++) begin
      tick(1);
      if (frame_a && level_a == 5'(target)) begin ok = 1'b1; break; end
    end
    check({name, "_seen"}, ok, 1);
    if (ok) begin
      cnt = 0;
      for (int j = 0; j < 32; j++) begin
        cnt += int'(pwm_a);
        tick(1);
      end
      check({name, "_high"}, cnt, target);
    end
  endtask

  initial begin
    int gap, trans;
    logic prev;
    bit nz;

    // reset held 3 cycles
    tick(3);
    check("rst_pwm", pwm_a, 0);
    check("rst_sq", sq_a, 0);
    check("rst_level", level_a, 0);
    check("rst_frame", frame_a, 0);
    rst = 1'b0;
    tick(1);
    check("first_frame", frame_a, 1);
    gap = 0;
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      if (frame_a) begin gap = j; break; end
    end
    check("frame_gap", gap, 32);

    // single voice
    write_a(0, 3, 15, 0);
    tick(5);
    prev = sq_a[0];
    trans = 0;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      if (sq_a[0] != prev) trans++;
      prev = sq_a[0];
    end
    check("sq_toggles_12", trans, 4);
    frame_high_count("lvl15", 15, 8 * 32);

    // full mix, second voice written exactly one square period later
    write_a(0, 40, 15, 0);
    tick(79);
    write_a(1, 40, 15, 0);
    frame_high_count("lvl30", 30, 12 * 32);

    // silence on ch1
    write_a(1, 0, 15, 0);
    nz = 1'b0;
    for (int j = 0; j < 50; j++) begin
      tick(1);
      if (sq_a[1]) nz = 1'b1;
    end
    check("silent_sq1", nz, 0);

    // decay: write coincident with a tick on the edge before a frame wrap
    while (((m_e + 1) % 32) != 0) tick(1);
    write_a(0, 32, 5, 1);
    tick(33);
    check("decay_wrap_frame", frame_a, 1);
    check("decay_write_wins", level_a, 1);
    tick(64);
    check("decay_floor_frame", frame_a, 1);
    check("decay_floor", level_a, 0);

    // mid-operation reset with both voices active
    write_a(0, 5, 9, 0);
    write_a(1, 7, 6, 0);
    write_b(2, 4, 11, 0);
    tick(45);
    rst = 1'b1;
    tick(1);
    check("mrst_pwm", pwm_a, 0);
    check("mrst_frame", frame_a, 0);
    check("mrst_level", level_a, 0);
    check("mrst_sq", sq_a, 0);
    check("mrst_sq_b", sq_b, 0);
    tick(2);
    rst = 1'b0;
    write_b(3, 1, 15, 1);
    nz = 1'b0;
    for (int j = 0; j < 100; j++) begin
      tick(1);
      if (sq_a != 0 || level_a != 0 || sq_b != 0 || level_b != 0) nz = 1'b1;
    end
    check("post_rst_silent", nz, 0);

    // randomized writes on both instances
    for (int j = 0; j < 4000; j++) begin
      rst = (j >= 2000 && j < 2002);
      wr_en_a = ($urandom_range(0, 7) == 0);
      wr_chan_a = 1'($urandom_range(0, 1));
      wr_en_b = ($urandom_range(0, 7) == 0);
      wr_chan_b = 2'($urandom_range(0, 3));
      wr_period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      wr_vol = 4'($urandom_range(0, 15));
      wr_decay = 1'($urandom_range(0, 1));
      tick(1);
    end
    rst = 1'b0;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    tick(2);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_music_poly.md
# pwm_music_poly

Parametrised polyphonic successor to the single-voice PWM music generator. It holds CHANNELS independent square-wave tone voices, each with a programmable period, a 4-bit-class volume and an optional linear decay envelope. The voice outputs are summed into a frame-latched duty value that drives a single-bit PWM DAC pin. It sits between a note sequencer or host register port and the top-level audio output (uo_out[7]).

## Interface
- CHANNELS, default 2: number of tone voices, 1..16.
- PERIOD_BITS, default 16: width of a voice half-period in clocks.
- VOL_BITS, default 4: per-voice volume width.
- DECAY_DIV, default 65536: clocks between envelope decay ticks, ≥2.
- Derived: CH_W = max(1, clog2(CHANNELS)); MIX_W = VOL_BITS + CH_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  voice write strobe, single cycle, no backpressure.
- wr_chan  in  CH_W  target voice; writes with wr_chan ≥ CHANNELS are ignored.
- wr_period  in  PERIOD_BITS  half-period in clocks; 0 = voice silent.
- wr_vol  in  VOL_BITS  initial volume.
- wr_decay  in  1  1 = enable envelope decay for this voice.
- pwm  out  1  registered PWM audio output.
- frame  out  1  one-cycle pulse in the first cycle of each PWM frame.
- level  out  MIX_W  duty latched for the current frame.
- sq  out  CHANNELS  raw square state of each voice, for debug.

## Operation
- Each voice holds period P, volume V, decay flag D, phase counter C and square bit S.
- Voice with P=0: C and S are held at 0.
- Voice with P>0: C counts 0..P-1. On the edge where C==P-1, C←0 and S toggles. Square period = 2P clocks.
- Write, effective on the next edge: P, V and D are loaded, and C←0, S←0 (phase restart).
- Decay prescaler counts 0..DECAY_DIV-1 and produces a one-cycle tick at the wrap. On a tick, every voice with D=1 and V>0 decrements V. V saturates at 0.
- Write and decay tick on the same voice in the same cycle: the written V wins and is not decremented.
- Mixer: mix = Σ (S ? V : 0) over all voices, MIX_W bits, never overflows.
- PWM frame counter K counts 0..2^MIX_W-1 and wraps.
- At each wrap, level←mix, sampled from the S and V values present on the wrap edge.
- pwm = 1 in frame cycle k if and only if k < level. level = 0 gives a constant low; the maximum level gives a high of level cycles per frame.
- Reset, including mid-operation: all P, V, D, C and S are cleared, the prescaler, K and level go to 0, pwm=0, frame=0, sq=0. The first frame pulse occurs in the first cycle after rst deasserts.

## Timing
- Write at edge n: sq restarts at 0 from cycle n+1. First toggle is at edge n+P.
- pwm, frame and level are registered outputs with no combinational path from the inputs.
- Latency from an S/V change to pwm: up to one full frame (2^MIX_W clocks) plus 1 cycle.
- frame is asserted in the same cycle that level takes its new value, with k=0.
- Decay ticks occur at edges DECAY_DIV, 2·DECAY_DIV, and so on, counted after reset.

## Structure
- Package pwm_music_pkg holds the default PERIOD_BITS and VOL_BITS values, the MIX_W/CH_W derivation functions, and the note-period constants used by sequencers.
- Sub-module pwm_tone_voice contains one voice (P, V, D, C, S, write and decay logic) and is instantiated CHANNELS times in a generate loop.
- Top level contains the decay prescaler, the mixer adder tree, and the PWM frame counter and comparator.

## Test plan
All scenarios use CHANNELS=2, VOL_BITS=4 (so MIX_W=5, frame = 32 clocks) and DECAY_DIV=8 unless stated otherwise.

- Reset: hold rst 3 cycles, then release.
  - pwm=0, sq=0, level=0.
  - frame pulses every 32 cycles, first pulse in the cycle after release.
- Single voice: write ch0 P=3, V=15, D=0.
  - sq[0] toggles every 3 clocks.
  - Every frame shows level ∈ {0,15}, matching sq[0] sampled at the wrap.
  - When level=15, pwm is high for exactly 15 of 32 cycles.
- Full mix: write ch0 and ch1 with P=40, V=15, in the same phase.
  - Once both S=1 at a wrap, level=30 and pwm is high 30 of 32 cycles.
- Decay: write ch0 P=1, V=3, D=1.
  - V (observed via level) steps 3→2→1→0 at successive decay ticks and stays at 0.
  - A write of V=5 coincident with a tick yields level 5, not 4.
- Silence and range: write ch1 P=0, V=15.
  - sq[1] stays 0 and contributes 0 to level.
  - With CHANNELS=3, a write to wr_chan=3 changes no state.
- Mid-operation reset: assert rst mid-frame with both voices active.
  - All outputs are 0 on the next cycle.
  - After release, voices stay silent until rewritten.
